quantization_pipe_wrapper: RTL and testbench

// Elastic, configurable quantization stage between accelerator output and SRAMC write port. Successor
// to the fixed 1-mode wrapper: N parallel lanes; runtime mode (bypass / shift-round / scale-shift-round);

---
 rtl/quantization_pipe_wrapper.sv | 182 ++++++++++++++++++
 tb/tb_quantization_pipe_wrapper.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantization_pipe_wrapper.sv
// Elastic three-stage quantization stage (multiply, round/shift/zero-point, saturate/pack) sitting
// between the accelerator output and the SRAM write port, with per-beat config capture and clamp stats.
module quantization_pipe_wrapper #(
  parameter int SRAMC_W  = 1024,
  parameter int ADRC_W   = 12,
  parameter int SRAMC_N  = 32,
  parameter int OUT_BITS = 8,
  parameter int SCALE_W  = 16,
  parameter int SHIFT_W  = 6,
  parameter int CNT_W    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_sramc_valid,
  output logic                       o_sramc_ready,
  input  logic [SRAMC_W-1:0]         i_sramc_wdata_q,
  input  logic [ADRC_W-1:0]          i_sramc_addr_q,
  input  logic                       i_sramc_wren_q,
  input  logic [0:SRAMC_N-1]         i_sramc_wmask_q,
  input  logic                       i_sramc_rden_q,
  output logic                       o_sramc_valid,
  input  logic                       i_sramc_ready,
  output logic [SRAMC_W-1:0]         o_sramc_wdata_q,
  output logic [ADRC_W-1:0]          o_sramc_addr_q,
  output logic                       o_sramc_wren_q,
  output logic [0:SRAMC_N-1]         o_sramc_wmask_q,
  output logic                       o_sramc_rden_q,
  input  logic                       i_cfg_load,
  input  logic [1:0]                 i_cfg_mode,
  input  logic [SHIFT_W-1:0]         i_cfg_shift,
  input  logic [SCALE_W-1:0]         i_cfg_scale,
  input  logic [OUT_BITS-1:0]        i_cfg_zp,
  output logic                       o_cfg_err,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_sat_cnt
);

  localparam int EL_W = SRAMC_W / SRAMC_N;
  localparam int PW   = EL_W + SCALE_W;
  localparam int QW   = PW + 2;
  localparam int PCW  = $clog2(SRAMC_N + 1);
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_SCL = 2'b10;
  localparam logic signed [QW-1:0] Q_MAX = (QW'(1) << (OUT_BITS - 1)) - QW'(1);
  localparam logic signed [QW-1:0] Q_MIN = -Q_MAX - QW'(1);

  // Handshake: a beat moves on a rising edge when valid & ready are both high on that port.
  // All three stages advance together on w_en and hold together otherwise, so an output beat
  // stays stable while o_sramc_valid & ~i_sramc_ready.
  logic w_en, w_accept, w_busy, w_cfg_ok, w_scl, w_quant;
  logic [SRAMC_N-1:0] w_on, w_sat;
  logic signed [PW-1:0] w_se;
  logic signed [QW-1:0] w_zpe;
  logic [PCW-1:0] w_sat_num;
  logic [CNT_W:0] w_cnt_sum;

  logic [1:0]          r_cfg_mode;
  logic [SHIFT_W-1:0]  r_cfg_shift;
  logic [SCALE_W-1:0]  r_cfg_scale;
  logic [OUT_BITS-1:0] r_cfg_zp;
  logic                r_cfg_err;
  logic [CNT_W-1:0]    r_sat_cnt;

  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic [ADRC_W-1:0] r_s1_addr, r_s2_addr, r_s3_addr;
  logic r_s1_wren, r_s2_wren, r_s3_wren;
  logic r_s1_rden, r_s2_rden, r_s3_rden;
  logic [0:SRAMC_N-1] r_s1_mask, r_s2_mask, r_s3_mask;
  logic r_s1_quant, r_s2_quant;
  logic [SRAMC_N-1:0] r_s1_on, r_s2_on;
  logic [SHIFT_W-1:0] r_s1_shift;
  logic [OUT_BITS-1:0] r_s1_zp;

  assign w_en     = i_sramc_ready | ~r_s3_valid;
  assign w_accept = i_sramc_valid & w_en;
  assign w_busy   = r_s1_valid | r_s2_valid | r_s3_valid;
  assign w_cfg_ok = i_cfg_load & ~w_busy & ~i_sramc_valid;
  assign w_scl    = (r_cfg_mode == MODE_SCL);
  assign w_quant  = (r_cfg_mode == MODE_SHR) | (r_cfg_mode == MODE_SCL);
  assign w_se     = {{EL_W{r_cfg_scale[SCALE_W-1]}}, r_cfg_scale};
  assign w_zpe    = {{(QW-OUT_BITS){r_s1_zp[OUT_BITS-1]}}, r_s1_zp};

  for (genvar k = 0; k < SRAMC_N; k++) begin : g_lane
    logic signed [EL_W-1:0] w_x;
    logic signed [PW-1:0]   w_xe, w_p, r_s1_p;
    logic signed [QW-1:0]   w_pe, w_rnd, w_sum, w_r, w_q, r_s2_q;
    logic [EL_W-1:0]        w_qc, r_s3_d;
    logic                   w_hi, w_lo, r_s3_sat;

    assign w_x     = i_sramc_wdata_q[k*EL_W +: EL_W];
    assign w_on[k] = i_sramc_wren_q & i_sramc_wmask_q[k];
    assign w_xe    = {{SCALE_W{w_x[EL_W-1]}}, w_x};
    assign w_p     = w_scl ? w_xe * w_se : w_xe;
    // Two guard bits keep the half-LSB rounding add and the zero-point add from overflowing.
    assign w_pe    = {{2{r_s1_p[PW-1]}}, r_s1_p};
    assign w_rnd   = (r_s1_shift == '0) ? '0 : (QW'(1) << (r_s1_shift - 1'b1));
    assign w_sum   = w_pe + w_rnd;
    assign w_r     = w_sum >>> r_s1_shift;
    assign w_q     = w_r + w_zpe;
    assign w_hi    = (r_s2_q > Q_MAX);
    assign w_lo    = (r_s2_q < Q_MIN);
    assign w_qc    = w_hi ? Q_MAX[EL_W-1:0] : (w_lo ? Q_MIN[EL_W-1:0] : r_s2_q[EL_W-1:0]);

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_s1_p   <= '0;
        r_s2_q   <= '0;
        r_s3_d   <= '0;
        r_s3_sat <= 1'b0;
      end else if (w_en) begin
        r_s1_p   <= w_p;
        r_s2_q   <= r_s1_quant ? w_q : w_pe;
        r_s3_d   <= !r_s2_on[k] ? '0 : (r_s2_quant ? w_qc : r_s2_q[EL_W-1:0]);
        r_s3_sat <= r_s2_on[k] & r_s2_quant & (w_hi | w_lo);
      end
    end

    assign o_sramc_wdata_q[k*EL_W +: EL_W] = r_s3_d;
    assign w_sat[k] = r_s3_sat;
  end

  always_comb begin
    w_sat_num = '0;
    for (int k = 0; k < SRAMC_N; k++) w_sat_num = w_sat_num + PCW'(w_sat[k]);
    w_cnt_sum = {1'b0, r_sat_cnt} + (CNT_W+1)'(w_sat_num);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cfg_mode  <= '0;
      r_cfg_shift <= '0;
      r_cfg_scale <= SCALE_W'(1);
      r_cfg_zp    <= '0;
      r_cfg_err   <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      r_cfg_err <= i_cfg_load & ~w_cfg_ok;
      if (w_cfg_ok) begin
        r_cfg_mode  <= i_cfg_mode;
        r_cfg_shift <= i_cfg_shift;
        r_cfg_scale <= i_cfg_scale;
        r_cfg_zp    <= i_cfg_zp;
        r_sat_cnt   <= '0;
      end else if (r_s3_valid & i_sramc_ready) begin
        r_sat_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_valid <= 1'b0; r_s2_valid <= 1'b0; r_s3_valid <= 1'b0;
      r_s1_addr  <= '0;   r_s2_addr  <= '0;   r_s3_addr  <= '0;
      r_s1_wren  <= 1'b0; r_s2_wren  <= 1'b0; r_s3_wren  <= 1'b0;
      r_s1_rden  <= 1'b0; r_s2_rden  <= 1'b0; r_s3_rden  <= 1'b0;
      r_s1_mask  <= '0;   r_s2_mask  <= '0;   r_s3_mask  <= '0;
      r_s1_quant <= 1'b0; r_s2_quant <= 1'b0;
      r_s1_on    <= '0;   r_s2_on    <= '0;
      r_s1_shift <= '0;   r_s1_zp    <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;        r_s2_valid <= r_s1_valid; r_s3_valid <= r_s2_valid;
      r_s1_addr  <= i_sramc_addr_q;  r_s2_addr  <= r_s1_addr;  r_s3_addr  <= r_s2_addr;
      r_s1_wren  <= i_sramc_wren_q;  r_s2_wren  <= r_s1_wren;  r_s3_wren  <= r_s2_wren;
      r_s1_rden  <= i_sramc_rden_q;  r_s2_rden  <= r_s1_rden;  r_s3_rden  <= r_s2_rden;
      r_s1_mask  <= i_sramc_wmask_q; r_s2_mask  <= r_s1_mask;  r_s3_mask  <= r_s2_mask;
      r_s1_quant <= w_quant;         r_s2_quant <= r_s1_quant;
      r_s1_on    <= w_on;            r_s2_on    <= r_s1_on;
      r_s1_shift <= r_cfg_shift;     r_s1_zp    <= r_cfg_zp;
    end
  end

  assign o_sramc_ready   = w_en;
  assign o_sramc_valid   = r_s3_valid;
  assign o_sramc_addr_q  = r_s3_addr;
  assign o_sramc_wren_q  = r_s3_wren;
  assign o_sramc_wmask_q = r_s3_mask;
  assign o_sramc_rden_q  = r_s3_rden;
  assign o_cfg_err       = r_cfg_err;
  assign o_busy          = w_busy;
  assign o_sat_cnt       = r_sat_cnt;

endmodule

// File: tb/tb_quantization_pipe_wrapper.sv
// Scoreboard bench for quantization_pipe_wrapper: directed beats push hand-computed results into
// exp_q; a negedge monitor pops and compares every beat the DUT hands downstream.
module tb_quantization_pipe_wrapper;
  localparam int SW = 1024;
  localparam int AW = 12;
  localparam int N  = 32;
  localparam int EL = 32;
  localparam int CW = AW + 1 + N + 1;
  localparam int EW = SW + CW;

  logic clk, rst_n;
  logic i_valid, o_ready, o_valid, i_ready;
  logic [SW-1:0] i_wdata, o_wdata;
  logic [AW-1:0] i_addr, o_addr;
  logic i_wren, o_wren, i_rden, o_rden;
  logic [0:N-1] i_mask, o_mask;
  logic cfg_load, cfg_err, busy;
  logic [1:0] cfg_mode;
  logic [5:0] cfg_shift;
  logic [15:0] cfg_scale, sat_cnt;
  logic [7:0] cfg_zp;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;
  logic held_v = 1'b0;

  quantization_pipe_wrapper #(
    .SRAMC_W(SW), .ADRC_W(AW), .SRAMC_N(N), .OUT_BITS(8), .SCALE_W(16), .SHIFT_W(6), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_sramc_valid(i_valid), .o_sramc_ready(o_ready),
    .i_sramc_wdata_q(i_wdata), .i_sramc_addr_q(i_addr), .i_sramc_wren_q(i_wren),
    .i_sramc_wmask_q(i_mask), .i_sramc_rden_q(i_rden),
    .o_sramc_valid(o_valid), .i_sramc_ready(i_ready),
    .o_sramc_wdata_q(o_wdata), .o_sramc_addr_q(o_addr), .o_sramc_wren_q(o_wren),
    .o_sramc_wmask_q(o_mask), .o_sramc_rden_q(o_rden),
    .i_cfg_load(cfg_load), .i_cfg_mode(cfg_mode), .i_cfg_shift(cfg_shift),
    .i_cfg_scale(cfg_scale), .i_cfg_zp(cfg_zp),
    .o_cfg_err(cfg_err), .o_busy(busy), .o_sat_cnt(sat_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic compare_beat(input logic [EW-1:0] a, input logic [EW-1:0] e);
    logic [SW-1:0] ad, ed;
    logic [CW-1:0] ac, ec;
    int bad;
    ad = a[EW-1 -: SW]; ed = e[EW-1 -: SW];
    ac = a[CW-1:0];     ec = e[CW-1:0];
    bad = -1;
    for (int k = N - 1; k >= 0; k--) if (ad[k*EL +: EL] !== ed[k*EL +: EL]) bad = k;
    checks++;
    if (a !== e) begin
      errors++;
      if (bad >= 0)
        $display("FAIL beat addr %h: lane %0d got %h expected %h", ec[CW-1 -: AW], bad,
                 ad[bad*EL +: EL], ed[bad*EL +: EL]);
      else
        $display("FAIL beat ctrl: got %h expected %h", ac, ec);
    end
  endtask

  // Scoreboard monitor: pops on each downstream handshake, checks stability while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && o_valid) begin
        checks++;
        if ({o_wdata, o_addr, o_wren, o_mask, o_rden} !== held) begin
          errors++;
          $display("FAIL stall_stable: outputs changed while stalled, addr got %h expected %h",
                   o_addr, held[CW-1 -: AW]);
        end
      end
      held_v = o_valid && !i_ready;
      held   = {o_wdata, o_addr, o_wren, o_mask, o_rden};
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %h expected no beat", o_addr);
        end else begin
          compare_beat({o_wdata, o_addr, o_wren, o_mask, o_rden}, exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  function automatic logic [SW-1:0] fill(input logic [EL-1:0] v);
    logic [SW-1:0] r;
    for (int k = 0; k < N; k++) r[k*EL +: EL] = v;
    return r;
  endfunction

  task automatic send(input logic [SW-1:0] d, input logic [SW-1:0] ed, input logic [AW-1:0] a,
                      input logic we, input logic [0:N-1] m, input logic re);
    logic acc;
    int t;
    exp_q.push_back({ed, a, we, m, re});
    i_valid = 1'b1; i_wdata = d; i_addr = a; i_wren = we; i_mask = m; i_rden = re;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      t++;
    end
    i_valid = 1'b0;
    if (!acc) check("send_accept_timeout", 64'(t), 64'd0);
  endtask

  task automatic load_cfg(input logic [1:0] md, input logic [5:0] sh, input logic [15:0] sc,
                          input logic [7:0] zp);
    cfg_load = 1'b1; cfg_mode = md; cfg_shift = sh; cfg_scale = sc; cfg_zp = zp;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 64'(t >= 200), 64'd0);
  endtask

  logic [SW-1:0] d, ed;
  logic [0:N-1] all_m, m5;
  logic [EL-1:0] lane0_exp[6];
  int lat, n0;

  initial begin
    all_m = '1;
    m5 = '1; m5[5] = 1'b0;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_wdata = '0; i_addr = '0;
    i_wren = 1'b0; i_mask = '0; i_rden = 1'b0;
    cfg_load = 1'b0; cfg_mode = '0; cfg_shift = '0; cfg_scale = '0; cfg_zp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("rst_wdata_zero", 64'(|o_wdata), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default config is bypass; masked-out lane4 forced to 0; latency 3 cycles
    d = fill('0);
    d[0*EL +: EL] = 32'h12345678; d[1*EL +: EL] = 32'h80000000;
    d[2*EL +: EL] = 32'hFFFFFFFF; d[3*EL +: EL] = 32'h00000007; d[4*EL +: EL] = 32'd55;
    ed = d; ed[4*EL +: EL] = '0;
    i_mask = all_m; i_mask[4] = 1'b0;
    send(d, ed, 12'h001, 1'b1, i_mask, 1'b0);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    wait_idle();

    // Mode 01, shift 4, zp 0
    load_cfg(2'b01, 6'd4, 16'd1, 8'd0);
    check("cfg_err_idle", 64'(cfg_err), 64'd0);
    d = fill('0);
    d[0*EL +: EL] = 32'd24; d[1*EL +: EL] = 32'hFFFFFFE8; d[2*EL +: EL] = 32'd5000;
    ed = fill('0);
    ed[0*EL +: EL] = 32'h00000002; ed[1*EL +: EL] = 32'hFFFFFFFF; ed[2*EL +: EL] = 32'h0000007F;
    send(d, ed, 12'h010, 1'b1, all_m, 1'b0);
    wait_idle();
    check("sat_cnt_mode01", 64'(sat_cnt), 64'd1);

    // Mode 10, scale 3, shift 1, zp -2; lane5 masked out
    load_cfg(2'b10, 6'd1, 16'd3, 8'hFE);
    check("sat_cnt_cleared_by_load", 64'(sat_cnt), 64'd0);
    d = fill('0);
    d[0*EL +: EL] = 32'd10; d[1*EL +: EL] = 32'h80000000; d[2*EL +: EL] = 32'hFFFFFFFB;
    d[3*EL +: EL] = 32'd1000; d[5*EL +: EL] = 32'd100;
    ed = fill(32'hFFFFFFFE);
    ed[0*EL +: EL] = 32'h0000000D; ed[1*EL +: EL] = 32'hFFFFFF80; ed[2*EL +: EL] = 32'hFFFFFFF7;
    ed[3*EL +: EL] = 32'h0000007F; ed[5*EL +: EL] = 32'h00000000;
    send(d, ed, 12'h020, 1'b1, m5, 1'b0);
    wait_idle();
    check("sat_cnt_mode10", 64'(sat_cnt), 64'd2);

    // Read beat: data zeroed, controls forwarded, no clamp counted
    send(fill(32'h7FFFFFFF), fill('0), 12'hABC, 1'b0, all_m, 1'b1);
    wait_idle();
    check("sat_cnt_read_beat", 64'(sat_cnt), 64'd2);

    // Six-beat stream with a 5-cycle downstream stall
    lane0_exp[0] = 32'hFFFFFFFE; lane0_exp[1] = 32'h00000001; lane0_exp[2] = 32'h00000004;
    lane0_exp[3] = 32'h00000007; lane0_exp[4] = 32'h0000000A; lane0_exp[5] = 32'h0000000D;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          d = fill('0); d[0 +: EL] = 32'(2 * i);
          ed = fill(32'hFFFFFFFE); ed[0 +: EL] = lane0_exp[i];
          send(d, ed, 12'(12'h100 + i), 1'b1, all_m, 1'b0);
        end
      end
      begin
        int t;
        t = 0;
        while (!o_valid && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        check("stall_wait_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_ready_low", 64'(o_ready), 64'd0);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    wait_idle();
    check("stream_beat_count", 64'(n_out - n0), 64'd6);

    // Config load while busy is rejected with a one-cycle error pulse
    d = fill('0); d[0 +: EL] = 32'd4;
    ed = fill(32'hFFFFFFFE); ed[0 +: EL] = 32'd4;
    send(d, ed, 12'h200, 1'b1, all_m, 1'b0);
    load_cfg(2'b01, 6'd4, 16'd1, 8'd0);
    check("cfg_err_pulse", 64'(cfg_err), 64'd1);
    @(posedge clk); #1;
    check("cfg_err_clear", 64'(cfg_err), 64'd0);
    wait_idle();
    send(d, ed, 12'h201, 1'b1, all_m, 1'b0);
    wait_idle();
    check("sat_cnt_after_reject", 64'(sat_cnt), 64'd2);
    load_cfg(2'b01, 6'd4, 16'd1, 8'd0);
    check("cfg_err_idle2", 64'(cfg_err), 64'd0);
    check("sat_cnt_cleared_idle", 64'(sat_cnt), 64'd0);
    d = fill('0); d[0 +: EL] = 32'd5000;
    ed = fill('0); ed[0 +: EL] = 32'h0000007F;
    send(d, ed, 12'h300, 1'b1, all_m, 1'b0);
    wait_idle();
    check("sat_cnt_before_reset", 64'(sat_cnt), 64'd1);

    // Reset with three beats in flight
    i_ready = 1'b0;
    d = fill('0); d[0 +: EL] = 32'd24;
    ed = fill('0); ed[0 +: EL] = 32'd2;
    for (int i = 0; i < 3; i++) send(d, ed, 12'(12'h400 + i), 1'b1, all_m, 1'b0);
    check("pre_reset_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    check("midrst_wdata_zero", 64'(|o_wdata), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    d = fill('0); d[0 +: EL] = 32'd24; d[1 +: EL] = '0; d[EL +: EL] = 32'hFFFFFFE8;
    send(d, d, 12'h500, 1'b1, all_m, 1'b0);
    wait_idle();
    check("post_reset_sat_cnt", 64'(sat_cnt), 64'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
